// File: rtl/i2c_pkg.sv
// Shared I2C initiator definitions: command encodings, FSM states, and the
// per-bit SDA drive rule (also used by the DAC sequencer).
package i2c_pkg;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2,
    CMD_STOP  = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_STOP,
    ST_RESP,
    ST_ABORT
  } state_e;

  // SDA pull-down for bit idx (0..7 data MSB first, 8 = ACK slot)
  function automatic logic bit_sda_oe(input cmd_op_e op, input logic [3:0] idx,
                                      input logic [7:0] data, input logic nack);
    logic v_oe;
    if (idx == 4'd8) v_oe = (op == CMD_READ) && !nack;
    else             v_oe = (op == CMD_WRITE) && !data[3'd7 - idx[2:0]];
    return v_oe;
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit prescaler: one-cycle tick every CLK_DIV cycles, frozen while
// the responder stretches SCL, with a stall timeout after STRETCH_MAX cycles.
module i2c_quarter_tick #(
  parameter int CLK_DIV     = 25,
  parameter int STRETCH_MAX = 4096
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_clear,
  input  logic i_hold,
  output logic o_tick,
  output logic o_timeout
);

  localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(STRETCH_MAX + 1);
  localparam logic [QW-1:0] LAST      = QW'(CLK_DIV - 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(STRETCH_MAX);

  logic [QW-1:0] r_cnt;
  logic [SW-1:0] r_stall;

  assign o_tick    = !i_clear && !i_hold && (r_cnt == LAST);
  assign o_timeout = !i_clear && i_hold && (r_stall == STALL_LIM);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt   <= '0;
      r_stall <= '0;
    end else begin
      if (i_clear || o_tick) r_cnt <= '0;
      else if (!i_hold)      r_cnt <= r_cnt + 1'b1;
      if (i_clear || !i_hold)         r_stall <= '0;
      else if (r_stall != STALL_LIM)  r_stall <= r_stall + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_initiator.sv
// Byte-level I2C initiator: executes one START/WRITE/READ/STOP primitive per
// accepted command and returns a single response pulse.
//   state | meaning
//   IDLE  | ready for a command
//   START | four quarters of (repeated) start condition
//   BIT   | nine bits of four quarters each (8 data + ACK)
//   STOP  | four quarters of stop condition
//   RESP  | one-cycle response pulse
//   ABORT | stretch timeout: SDA already released, release SCL
module i2c_initiator
  import i2c_pkg::*;
#(
  parameter int CLK_DIV     = 25,
  parameter int STRETCH_MAX = 4096
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic       cmd_nack,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_nack,
  output logic       rsp_err,
  output logic       busy,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe
);

  state_e     r_state, w_state_nxt;
  cmd_op_e    r_op, w_cmd_op;
  logic [1:0] r_q;
  logic [3:0] r_bit;
  logic [7:0] r_wdata, r_shift, r_rsp_data;
  logic       r_nack_cmd, r_ack, r_scl_oe, r_sda_oe, r_busy, r_rsp_nack, r_rsp_err;
  logic       w_accept, w_legal, w_active, w_hold, w_tick, w_timeout, w_done;
  logic       w_scl_nxt, w_sda_nxt, w_rsp_err_nxt;

  assign w_cmd_op = cmd_op_e'(cmd_op);
  assign w_accept = (r_state == ST_IDLE) && cmd_valid;
  assign w_legal  = (w_cmd_op == CMD_START) || r_busy;
  assign w_active = (r_state == ST_START) || (r_state == ST_BIT) || (r_state == ST_STOP);
  // quarter 1 always releases SCL, so that is where the responder may stretch
  assign w_hold   = w_active && (r_q == 2'd1) && !scl_i;
  assign w_done   = w_tick && (r_q == 2'd3) && ((r_state != ST_BIT) || (r_bit == 4'd8));

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV), .STRETCH_MAX(STRETCH_MAX)) u_tick (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .i_clear   (!w_active),
    .i_hold    (w_hold),
    .o_tick    (w_tick),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        if (!w_legal)                    w_state_nxt = ST_RESP;
        else if (w_cmd_op == CMD_START)  w_state_nxt = ST_START;
        else if (w_cmd_op == CMD_STOP)   w_state_nxt = ST_STOP;
        else                             w_state_nxt = ST_BIT;
      end
      ST_START, ST_BIT, ST_STOP: begin
        if (w_timeout)   w_state_nxt = ST_ABORT;
        else if (w_done) w_state_nxt = ST_RESP;
      end
      ST_ABORT: w_state_nxt = ST_RESP;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Next line levels, applied at the start of each quarter
  always_comb begin
    w_scl_nxt     = r_scl_oe;
    w_sda_nxt     = r_sda_oe;
    w_rsp_err_nxt = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) begin
        if (!w_legal)                   w_rsp_err_nxt = 1'b1;
        else if (w_cmd_op == CMD_START) w_sda_nxt = 1'b0;
        else if (w_cmd_op == CMD_STOP)  w_sda_nxt = 1'b1;
        else w_sda_nxt = bit_sda_oe(w_cmd_op, 4'd0, cmd_data, cmd_nack);
      end
      ST_START, ST_BIT, ST_STOP: begin
        if (w_timeout) w_sda_nxt = 1'b0;
        else if (w_tick) begin
          case (r_q)
            2'd0: w_scl_nxt = 1'b0;
            2'd1: begin
              if (r_state == ST_START)     w_sda_nxt = 1'b1;
              else if (r_state == ST_STOP) w_sda_nxt = 1'b0;
            end
            2'd2: if (r_state != ST_STOP) w_scl_nxt = 1'b1;
            default: if ((r_state == ST_BIT) && (r_bit != 4'd8))
              w_sda_nxt = bit_sda_oe(r_op, 4'(r_bit + 4'd1), r_wdata, r_nack_cmd);
          endcase
        end
      end
      ST_ABORT: begin
        w_scl_nxt     = 1'b0;
        w_rsp_err_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_op       <= CMD_START;
      r_q        <= '0;
      r_bit      <= '0;
      r_wdata    <= '0;
      r_shift    <= '0;
      r_nack_cmd <= 1'b0;
      r_ack      <= 1'b0;
      r_scl_oe   <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_nack <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_scl_oe <= w_scl_nxt;
      r_sda_oe <= w_sda_nxt;
      if (w_accept) begin
        r_op       <= w_cmd_op;
        r_wdata    <= cmd_data;
        r_nack_cmd <= cmd_nack;
        r_q        <= '0;
        r_bit      <= '0;
        if (w_legal && (w_cmd_op == CMD_START)) r_busy <= 1'b1;
      end
      if (w_active && w_tick) begin
        r_q <= r_q + 2'd1;
        if (r_q == 2'd3) r_bit <= r_bit + 4'd1;
        if ((r_state == ST_BIT) && (r_q == 2'd2)) begin
          if (r_bit == 4'd8) r_ack   <= sda_i;
          else               r_shift <= {r_shift[6:0], sda_i};
        end
      end
      if (w_state_nxt == ST_RESP) begin
        r_rsp_err  <= w_rsp_err_nxt;
        r_rsp_data <= ((r_state == ST_BIT) && (r_op == CMD_READ)) ? r_shift : 8'h00;
        r_rsp_nack <= (r_state == ST_BIT) && (r_op == CMD_WRITE) && r_ack;
        if ((r_state == ST_STOP) || (r_state == ST_ABORT)) r_busy <= 1'b0;
      end
    end
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rsp_data;
  assign rsp_nack  = r_rsp_nack;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;
  assign scl_oe    = r_scl_oe;
  assign sda_oe    = r_sda_oe;

endmodule
